// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state and main-memory defaults.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_LAT_DEFAULT   = 2;
  localparam int RAM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/ram_array.sv
// Word storage for main memory: one asynchronous read port, one synchronous write port.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  word_t mem [DEPTH];

  // NOTE: storage has no reset; clearing a whole array costs a mux per bit and software never relies on it.
  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ram_latency_ctrl.sv
// Main-memory controller: fixed-latency request service over ram_array, progress on ramstate.
// Optional macro RAM_ADDR_CHECK_EN flags out-of-range or misaligned addresses as ERROR.
module ram_latency_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT   = RAM_LAT_DEFAULT,
  parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} fsm_t;

  fsm_t       state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lat_ren_q, lat_ren_d;
  logic       lat_wen_q, lat_wen_d;
  word_t      lat_addr_q, lat_addr_d;
  ramstate_t  st;
  logic       we;
  logic       req;
  logic       req_changed;
  logic       addr_err;
  word_t      rdata;

  assign req         = ramREN | ramWEN;
  assign req_changed = {ramREN, ramWEN, ramaddr} != {lat_ren_q, lat_wen_q, lat_addr_q};

`ifdef RAM_ADDR_CHECK_EN
  assign addr_err = (ramaddr >= 32'(DEPTH * 4)) || (ramaddr[1:0] != 2'b00);
`else
  assign addr_err = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_ren_d  = lat_ren_q;
    lat_wen_d  = lat_wen_q;
    lat_addr_d = lat_addr_q;
    st         = FREE;
    we         = 1'b0;
    if (RST) begin
      st = FREE;
    end else if ((ramREN && ramWEN) || (req && addr_err)) begin
      st      = ERROR;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (LAT == 0) begin
              st = ACCESS;
              we = ramWEN;
            end else begin
              st         = BUSY;
              cnt_d      = LAT_M1;
              lat_ren_d  = ramREN;
              lat_wen_d  = ramWEN;
              lat_addr_d = ramaddr;
              state_d    = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_d = S_IDLE;
          end else if (req_changed) begin
            // Requester re-arbitrated: restart the full latency for the new request.
            st         = BUSY;
            cnt_d      = LAT_M1;
            lat_ren_d  = ramREN;
            lat_wen_d  = ramWEN;
            lat_addr_d = ramaddr;
          end else if (cnt_q != 4'd0) begin
            st    = BUSY;
            cnt_d = cnt_q - 4'd1;
          end else begin
            st      = ACCESS;
            we      = ramWEN;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      lat_ren_q  <= 1'b0;
      lat_wen_q  <= 1'b0;
      lat_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_ren_q  <= lat_ren_d;
      lat_wen_q  <= lat_wen_d;
      lat_addr_q <= lat_addr_d;
    end
  end

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .we    (we),
    .idx   (ramaddr[IDX_W+1:2]),
    .wdata (ramstore),
    .rdata (rdata)
  );

  assign ramstate = st;
  assign ramload  = (st == ACCESS && ramREN) ? rdata : 32'd0;

endmodule
